// File: rtl/data_mux_arb_pkg.sv
// data_mux_arb_pkg: shared state encoding and channel-index width helper for data_mux_arb.
package data_mux_arb_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    // Bits needed to hold indices 0..n-1 (6->3, 8->3, 9->4).
    function automatic int logb2(input int n);
        int v;
        int r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/data_mux_arb_rr_pick.sv
// data_mux_arb_rr_pick: combinational round-robin selector, first request after ptr, wrapping modulo N.
module data_mux_arb_rr_pick
    import data_mux_arb_pkg::*;
#(
    parameter int N = 6,
    parameter int W = logb2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    int c;
    // Scan farthest offset first so the nearest request after ptr wins.
    always_comb begin
        idx = '0;
        found = 1'b0;
        c = 0;
        for (int i = N; i >= 1; i--) begin
            c = (int'(ptr) + i) % N;
            if (req[c]) begin
                idx = W'(c);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/data_mux_arb.sv
// data_mux_arb: packet-aware N-to-1 round-robin mux regenerating the source index on m_sel.
// Define DATA_MUX_ARB_PKT_CNT_EN to add per-channel completed-packet counters (pkt_cnt).
module data_mux_arb
    import data_mux_arb_pkg::*;
#(
    parameter int CHN_NUM = 6,
    parameter int DWID    = 256,
    parameter int NUMWID  = logb2(CHN_NUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHN_NUM-1:0]      s_valid,
    input  logic [DWID*CHN_NUM-1:0] s_data,
    input  logic [CHN_NUM-1:0]      s_last,
    output logic [CHN_NUM-1:0]      s_ready,
    output logic                    m_valid,
    output logic [DWID-1:0]         m_data,
    output logic                    m_last,
    output logic [NUMWID-1:0]       m_sel,
    input  logic                    m_ready
`ifdef DATA_MUX_ARB_PKT_CNT_EN
    ,
    output logic [32*CHN_NUM-1:0]   pkt_cnt
`endif
);
    state_t state, state_n;
    logic [NUMWID-1:0] gnt, ptr, pick;
    logic found, open, xfer, cur_valid, cur_last;
    logic [DWID-1:0] cur_data;

    data_mux_arb_rr_pick #(.N(CHN_NUM), .W(NUMWID)) u_pick (
        .req  (s_valid),
        .ptr  (ptr),
        .idx  (pick),
        .found(found)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign open = !m_valid || m_ready;
    assign xfer = state == BUSY && open && cur_valid;

    always_comb begin
        cur_valid = 1'b0;
        cur_last = 1'b0;
        cur_data = '0;
        s_ready = '0;
        for (int i = 0; i < CHN_NUM; i++) begin
            if (gnt == NUMWID'(i)) begin
                cur_valid = s_valid[i];
                cur_last = s_last[i];
                cur_data = s_data[DWID*i +: DWID];
                s_ready[i] = state == BUSY && open;
            end
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && found)
            state_n = BUSY;
        else if (xfer && cur_last)
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            ptr <= NUMWID'(CHN_NUM - 1);
            m_valid <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            m_sel <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found)
                gnt <= pick;
            if (xfer && cur_last)
                ptr <= gnt;
            if (xfer) begin
                m_valid <= 1'b1;
                m_data <= cur_data;
                m_last <= cur_last;
                m_sel <= gnt;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef DATA_MUX_ARB_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            pkt_cnt <= '0;
        else
            for (int i = 0; i < CHN_NUM; i++)
                if (xfer && cur_last && gnt == NUMWID'(i))
                    pkt_cnt[32*i +: 32] <= pkt_cnt[32*i +: 32] + 32'd1;
    end
`endif
endmodule

// File: tb/tb_data_mux_arb.sv
// tb_data_mux_arb: directed checks of data_mux_arb arbitration, packet hold, backpressure and reset.
// Under DATA_MUX_ARB_PKT_CNT_EN the packet counters are checked too.
module tb_data_mux_arb;
    localparam int N = 6;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] s_valid, s_last, s_ready;
    logic [DW*N-1:0] s_data;
    logic m_valid, m_last, m_ready;
    logic [DW-1:0] m_data;
    logic [2:0] m_sel;
`ifdef DATA_MUX_ARB_PKT_CNT_EN
    logic [32*N-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    data_mux_arb #(.CHN_NUM(N), .DWID(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_data (s_data),
        .s_last (s_last),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data (m_data),
        .m_last (m_last),
        .m_sel  (m_sel),
        .m_ready(m_ready)
`ifdef DATA_MUX_ARB_PKT_CNT_EN
        ,
        .pkt_cnt(pkt_cnt)
`endif
    );

    typedef struct {
        logic [15:0] d;
        logic [2:0]  s;
        logic        l;
        int          t;
    } beat_t;
    beat_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rem[N], plen[N], npk[N], bidx[N];
    logic [N-1:0] en;
    logic [N-1:0] sn_sr;
    logic sn_mv, sn_ml;
    logic [15:0] sn_md;
    logic [2:0] sn_ms;

    // Channel c beat b carries data {c, b}; last flags the final beat of each packet.
    task automatic drive();
        for (int c = 0; c < N; c++) begin
            s_valid[c] = en[c] && rem[c] != 0;
            s_last[c] = rem[c] == 1;
            s_data[DW*c +: DW] = {8'(c), 8'(bidx[c])};
        end
    endtask

    task automatic load(input int c, input int len, input int pk);
        rem[c] = len;
        plen[c] = len;
        npk[c] = pk;
        bidx[c] = 0;
        drive();
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        sn_sr = s_ready;
        sn_mv = m_valid;
        sn_md = m_data;
        sn_ml = m_last;
        sn_ms = m_sel;
        acc = s_valid & s_ready;
        if (m_valid && m_ready)
            q.push_back('{m_data, m_sel, m_last, cyc});
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < N; c++) begin
            if (acc[c]) begin
                bidx[c]++;
                rem[c]--;
                if (rem[c] == 0 && npk[c] > 0) begin
                    npk[c]--;
                    rem[c] = plen[c];
                end
            end
        end
        drive();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input int n);
        int b;
        b = 0;
        while (q.size() < n && b < 300) begin
            tick();
            b++;
        end
        chk("drain_count", 64'(q.size()), 64'(n));
        tick();
        tick();
    endtask

    initial begin
        int ch, bi;
        logic [2:0] e_sel[6];
        logic [15:0] e_dat[6];
        logic e_lst[6];
        rst = 1'b1;
        m_ready = 1'b1;
        en = '1;
        for (int c = 0; c < N; c++)
            load(c, 1, 0);
        // Reset with every channel requesting.
        tick();
        tick();
        chk("rst_m_valid", 64'(sn_mv), 64'(0));
        chk("rst_m_data", 64'(sn_md), 64'(0));
        chk("rst_m_last", 64'(sn_ml), 64'(0));
        chk("rst_m_sel", 64'(sn_ms), 64'(0));
        chk("rst_s_ready", 64'(sn_sr), 64'(0));
        rst = 1'b0;
        tick();
        chk("idle_s_ready", 64'(sn_sr), 64'(0));
        tick();
        chk("first_grant_ch0", 64'(sn_sr), 64'(6'b000001));
        chk("first_beat_pending", 64'(sn_mv), 64'(0));
        tick();
        chk("first_m_valid", 64'(sn_mv), 64'(1));
        chk("first_m_sel", 64'(sn_ms), 64'(0));
        chk("first_m_data", 64'(sn_md), 64'(16'h0000));
        chk("first_m_last", 64'(sn_ml), 64'(1));
        chk("first_idle_ready", 64'(sn_sr), 64'(0));
        drain(6);
        for (int k = 0; k < 6; k++) begin
            chk("rr_order_sel", 64'(q[k].s), 64'(k));
            chk("rr_order_data", 64'(q[k].d), 64'({8'(k), 8'h00}));
        end
        // Channels 1 and 4: two 3-beat packets each, alternating.
        q.delete();
        load(1, 3, 1);
        load(4, 3, 1);
        drain(12);
        for (int k = 0; k < 12; k++) begin
            ch = ((k / 3) % 2 == 1) ? 4 : 1;
            bi = ((k / 3) / 2) * 3 + k % 3;
            chk("alt_sel", 64'(q[k].s), 64'(ch));
            chk("alt_data", 64'(q[k].d), 64'({8'(ch), 8'(bi)}));
            chk("alt_last", 64'(q[k].l), 64'(k % 3 == 2));
            if (k > 0)
                chk("alt_gap", 64'(q[k].t - q[k-1].t), 64'((k % 3 == 0) ? 2 : 1));
        end
        // Wrap: last served 5, channels 0 and 5 both request.
        q.delete();
        load(5, 1, 0);
        drain(1);
        load(0, 1, 0);
        load(5, 1, 0);
        drain(3);
        chk("wrap_sel0", 64'(q[0].s), 64'(5));
        chk("wrap_sel1", 64'(q[1].s), 64'(0));
        chk("wrap_sel2", 64'(q[2].s), 64'(5));
        // Backpressure mid-packet on channel 2.
        q.delete();
        load(2, 6, 0);
        repeat (4) tick();
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_valid", 64'(sn_mv), 64'(1));
            chk("bp_data", 64'(sn_md), 64'(16'h0202));
            chk("bp_sel", 64'(sn_ms), 64'(2));
            chk("bp_last", 64'(sn_ml), 64'(0));
            chk("bp_s_ready", 64'(sn_sr), 64'(0));
        end
        m_ready = 1'b1;
        drain(6);
        for (int k = 0; k < 6; k++) begin
            chk("bp_sb_data", 64'(q[k].d), 64'({8'h02, 8'(k)}));
            chk("bp_sb_last", 64'(q[k].l), 64'(k == 5));
        end
        // Channel 2 stalls mid-packet while channel 3 waits.
        q.delete();
        load(2, 4, 0);
        repeat (3) tick();
        en[2] = 1'b0;
        load(3, 2, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_s_ready", 64'(sn_sr), 64'(6'b000100));
            chk("stall_sel", 64'(sn_ms), 64'(2));
        end
        en[2] = 1'b1;
        drive();
        drain(6);
        e_sel = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3};
        e_dat = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0300, 16'h0301};
        e_lst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            chk("hold_sel", 64'(q[k].s), 64'(e_sel[k]));
            chk("hold_data", 64'(q[k].d), 64'(e_dat[k]));
            chk("hold_last", 64'(q[k].l), 64'(e_lst[k]));
        end
        // Reset mid-packet discards the rest of channel 1's packet.
        q.delete();
        load(1, 4, 0);
        repeat (3) tick();
        rem[1] = 0;
        drive();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(sn_mv), 64'(0));
        chk("mid_rst_data", 64'(sn_md), 64'(0));
        chk("mid_rst_last", 64'(sn_ml), 64'(0));
        chk("mid_rst_sel", 64'(sn_ms), 64'(0));
        chk("mid_rst_ready", 64'(sn_sr), 64'(0));
        chk("mid_rst_beats", 64'(q.size()), 64'(2));
        for (int k = 0; k < q.size(); k++)
            chk("mid_rst_no_last", 64'(q[k].l), 64'(0));
`ifdef DATA_MUX_ARB_PKT_CNT_EN
        q.delete();
        load(1, 2, 4);
        drain(10);
        for (int c = 0; c < N; c++)
            chk("pkt_cnt", 64'(pkt_cnt[32*c +: 32]), 64'((c == 1) ? 5 : 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < N; c++)
            chk("pkt_cnt_rst", 64'(pkt_cnt[32*c +: 32]), 64'(0));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
